// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues single outstanding reads to instruction
// memory, buffers one returned instruction for the IF/ID register, and
// handles branch redirects by dropping in-flight responses.
//
// Handshakes:
//   imem request  : a request is accepted on a cycle where imem_req && imem_ready;
//                   imem_addr is held stable while imem_req && !imem_ready.
//   imem response : the single outstanding read returns on the cycle imem_rvalid=1;
//                   rvalid is only meaningful in WAIT/DROP and ignored elsewhere.
//   IF/ID transfer: the buffered instruction moves downstream on a cycle where
//                   out_valid && !if_id_stall; with if_id_stall=1 it is held.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        out_valid,
  output logic [1:0]  fetch_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        consume;
  logic        accept;
  logic        load;
  logic [31:0] redirect_pc;

  // The two low target bits are forced to zero on redirect and never used.
  logic        unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // Handshake qualifiers derived from current state and inputs
  always_comb begin
    consume     = buf_valid && !if_id_stall;
    imem_req    = (state == ST_REQ) && (!buf_valid || consume);
    imem_addr   = pc;
    accept      = imem_req && imem_ready;
    load        = (state == ST_WAIT) && imem_rvalid && !branch_taken;
    redirect_pc = {branch_target[31:2], 2'b00};
  end

  // Next-state and next-pc selection; redirect wins over a same-cycle accept
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (branch_taken) begin
      pc_next = redirect_pc;
    end else if (accept) begin
      pc_next = pc + 32'd4;
    end
    case (state)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (accept) state_next = branch_taken ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (branch_taken) state_next = imem_rvalid ? ST_REQ : ST_DROP;
        else if (imem_rvalid) state_next = ST_REQ;
      end
      ST_DROP: begin
        if (imem_rvalid) state_next = ST_REQ;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM, program counter and outstanding-request address registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (accept) req_pc <= pc;
    end
  end

  // Single-entry response buffer feeding IF/ID; redirect flushes it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'h0000_0000;
    end else if (branch_taken) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_instr <= imem_rdata;
      buf_pc    <= req_pc;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  // Downstream view of the buffer; a bubble shows NOP with the last pc
  always_comb begin
    out_valid       = buf_valid;
    out_instruction = buf_valid ? buf_instr : NOP_INSTR;
    out_pc          = buf_pc;
    fetch_state     = state;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Inputs change on the falling edge,
// outputs are checked 1ns later. A tiny memory responder inside the drive
// task returns data = 32'hC0DE0000 ^ addr, mem_lat cycles after accept.
module tb_if_fetch_unit;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        if_id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        out_valid;
  logic [1:0]  fetch_state;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst_val;
  int          mem_lat;
  logic        pend_active;
  int          pend_cnt;
  logic [31:0] pend_addr;

  if_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .if_id_stall     (if_id_stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_valid       (out_valid),
    .fetch_state     (fetch_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: drive inputs at negedge, run the memory responder,
  // settle, then record whether this cycle's request is accepted.
  task automatic drive(input logic br, input logic [31:0] tgt, input logic st, input logic rdy);
    @(negedge clock);
    reset         = rst_val;
    branch_taken  = br;
    branch_target = tgt;
    if_id_stall   = st;
    imem_ready    = rdy;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    if (pend_active) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC0DE_0000 ^ pend_addr;
        pend_active = 1'b0;
      end
    end
    #1;
    if (imem_req && imem_ready) begin
      pend_active = 1'b1;
      pend_cnt    = mem_lat;
      pend_addr   = imem_addr;
    end
  endtask

  initial begin
    rst_val = 1'b1; mem_lat = 1; pend_active = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    reset = 1'b1; if_id_stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #2;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instruction, NOP);
    check("rst_pc", out_pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_state", {30'b0, fetch_state}, {30'b0, ST_IDLE});

    // Zero-wait streaming and first-fetch latency
    rst_val = 1'b0;
    drive(0, 0, 0, 1);                                  // c1 IDLE
    check("c1_req", {31'b0, imem_req}, 32'h0);
    check("c1_state", {30'b0, fetch_state}, {30'b0, ST_IDLE});
    drive(0, 0, 0, 1);                                  // c2 REQ pc 0
    check("c2_req", {31'b0, imem_req}, 32'h1);
    check("c2_addr", imem_addr, 32'h0);
    drive(0, 0, 0, 1);                                  // c3 WAIT, rvalid
    check("c3_state", {30'b0, fetch_state}, {30'b0, ST_WAIT});
    check("c3_valid", {31'b0, out_valid}, 32'h0);
    drive(0, 0, 0, 1);                                  // c4 out 0
    check("c4_valid", {31'b0, out_valid}, 32'h1);
    check("c4_pc", out_pc, 32'h0);
    check("c4_instr", out_instruction, 32'hC0DE_0000);
    check("c4_addr", imem_addr, 32'h4);
    drive(0, 0, 0, 1);                                  // c5 bubble
    check("c5_valid", {31'b0, out_valid}, 32'h0);
    check("c5_instr", out_instruction, NOP);
    drive(0, 0, 0, 1);                                  // c6 out 4
    check("c6_pc", out_pc, 32'h4);
    check("c6_instr", out_instruction, 32'hC0DE_0004);
    drive(0, 0, 0, 1);                                  // c7 rvalid for 8

    // Stall with buffer full at pc 8
    for (int i = 0; i < 3; i++) begin                   // c8..c10
      drive(0, 0, 1, 1);
      check("stall_valid", {31'b0, out_valid}, 32'h1);
      check("stall_pc", out_pc, 32'h8);
      check("stall_instr", out_instruction, 32'hC0DE_0008);
      check("stall_req", {31'b0, imem_req}, 32'h0);
    end
    drive(0, 0, 0, 1);                                  // c11 release
    check("c11_pc", out_pc, 32'h8);
    check("c11_req", {31'b0, imem_req}, 32'h1);
    check("c11_addr", imem_addr, 32'hC);
    drive(0, 0, 0, 1);                                  // c12
    check("c12_valid", {31'b0, out_valid}, 32'h0);
    mem_lat = 3;
    drive(0, 0, 0, 1);                                  // c13 out C, req 0x10
    check("c13_pc", out_pc, 32'hC);
    check("c13_instr", out_instruction, 32'hC0DE_000C);
    check("c13_addr", imem_addr, 32'h10);

    // Redirect while waiting on 0x10
    drive(1, 32'h103, 0, 1);                            // c14 WAIT, redirect
    check("c14_state", {30'b0, fetch_state}, {30'b0, ST_WAIT});
    drive(0, 0, 0, 1);                                  // c15 DROP
    check("c15_state", {30'b0, fetch_state}, {30'b0, ST_DROP});
    check("c15_req", {31'b0, imem_req}, 32'h0);
    mem_lat = 1;
    drive(0, 0, 0, 1);                                  // c16 stale rvalid dropped
    check("c16_valid", {31'b0, out_valid}, 32'h0);
    drive(0, 0, 0, 1);                                  // c17 REQ 0x100
    check("c17_valid", {31'b0, out_valid}, 32'h0);
    check("c17_addr", imem_addr, 32'h100);
    check("c17_req", {31'b0, imem_req}, 32'h1);
    drive(0, 0, 0, 1);                                  // c18
    check("c18_valid", {31'b0, out_valid}, 32'h0);

    // Redirect plus stall with a valid buffer
    drive(1, 32'h200, 1, 1);                            // c19
    check("c19_valid", {31'b0, out_valid}, 32'h1);
    check("c19_pc", out_pc, 32'h100);
    check("c19_instr", out_instruction, 32'hC0DE_0100);
    drive(0, 0, 1, 1);                                  // c20
    check("c20_valid", {31'b0, out_valid}, 32'h0);
    check("c20_instr", out_instruction, NOP);
    check("c20_pc", out_pc, 32'h100);
    check("c20_addr", imem_addr, 32'h200);
    check("c20_req", {31'b0, imem_req}, 32'h1);
    drive(0, 0, 0, 1);                                  // c21 rvalid 0x200
    drive(1, 32'h20, 0, 1);                             // c22 accept 0x204 + redirect
    check("c22_pc", out_pc, 32'h200);
    check("c22_instr", out_instruction, 32'hC0DE_0200);
    check("c22_addr", imem_addr, 32'h204);
    drive(0, 0, 0, 1);                                  // c23 DROP, stale rvalid
    check("c23_state", {30'b0, fetch_state}, {30'b0, ST_DROP});
    check("c23_valid", {31'b0, out_valid}, 32'h0);

    // Memory not ready for 4 cycles at 0x20
    for (int i = 0; i < 4; i++) begin                   // c24..c27
      drive(0, 0, 0, 0);
      check("nrdy_req", {31'b0, imem_req}, 32'h1);
      check("nrdy_addr", imem_addr, 32'h20);
    end
    drive(0, 0, 0, 1);                                  // c28 accept
    check("c28_addr", imem_addr, 32'h20);
    drive(0, 0, 0, 1);                                  // c29
    check("c29_state", {30'b0, fetch_state}, {30'b0, ST_WAIT});
    mem_lat = 2;
    drive(0, 0, 0, 1);                                  // c30 out 0x20, req 0x24
    check("c30_pc", out_pc, 32'h20);
    check("c30_instr", out_instruction, 32'hC0DE_0020);
    check("c30_addr", imem_addr, 32'h24);

    // Reset in WAIT, stale response after release
    rst_val = 1'b1;
    drive(0, 0, 0, 1);                                  // c31 async reset
    check("c31_state", {30'b0, fetch_state}, {30'b0, ST_IDLE});
    check("c31_valid", {31'b0, out_valid}, 32'h0);
    check("c31_instr", out_instruction, NOP);
    check("c31_pc", out_pc, 32'h0);
    check("c31_req", {31'b0, imem_req}, 32'h0);
    rst_val = 1'b0;
    mem_lat = 1;
    drive(0, 0, 0, 1);                                  // c32 IDLE, stale rvalid
    check("c32_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
    check("c32_state", {30'b0, fetch_state}, {30'b0, ST_IDLE});
    drive(0, 0, 0, 1);                                  // c33 REQ RESET_PC
    check("c33_valid", {31'b0, out_valid}, 32'h0);
    check("c33_addr", imem_addr, 32'h0);
    check("c33_req", {31'b0, imem_req}, 32'h1);
    drive(0, 0, 0, 1);                                  // c34
    check("c34_valid", {31'b0, out_valid}, 32'h0);
    drive(0, 0, 0, 1);                                  // c35
    check("c35_valid", {31'b0, out_valid}, 32'h1);
    check("c35_pc", out_pc, 32'h0);
    check("c35_instr", out_instruction, 32'hC0DE_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning the instruction presented when no valid instruction is held.
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port if_id_stall, input, 1, downstream IF/ID register holding; no transfer this cycle.
REQ-006 SHALL have port branch_taken, input, 1, redirect request from EX.
REQ-007 SHALL have port branch_target, input, 32, redirect address.
REQ-008 SHALL have port imem_req, output, 1, instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32, request address.
REQ-010 SHALL have port imem_ready, input, 1, memory accepts request this cycle.
REQ-011 SHALL have port imem_rvalid, input, 1, read data valid.
REQ-012 SHALL have port imem_rdata, input, 32, read data.
REQ-013 SHALL have port out_instruction, output, 32, instruction to IF/ID.
REQ-014 SHALL have port out_pc, output, 32, address of out_instruction.
REQ-015 SHALL have port out_valid, output, 1, out_instruction is a real fetched instruction.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-017 SHALL, in IDLE, drive imem_req=0 and move to REQ next cycle unconditionally.
REQ-018 SHALL, in REQ, drive imem_req=1 only when the response buffer is empty or is consumed this cycle; imem_addr=pc.
REQ-019 SHALL, on accept (imem_req && imem_ready), latch req_pc=pc, set pc=pc+4 (mod 2^32), enter WAIT.
REQ-020 SHALL keep imem_addr stable while imem_req=1 and imem_ready=0, except on redirect.
REQ-021 SHALL, in WAIT on imem_rvalid, load buffer {imem_rdata, req_pc}, set buffer valid, return to REQ.
REQ-022 SHALL drive out_instruction/out_pc/out_valid from the buffer; when buffer empty, out_instruction=NOP_INSTR, out_pc=last buffered pc, out_valid=0.
REQ-023 SHALL consume the buffer (transfer) on a cycle with out_valid=1 and if_id_stall=0; with if_id_stall=1 buffer contents SHALL hold unchanged.
REQ-024 SHALL, on branch_taken=1, set pc={branch_target[31:2],2'b00}, clear buffer valid, regardless of if_id_stall (redirect has priority over stall).
REQ-025 SHALL, on redirect while in WAIT without imem_rvalid, or in REQ with accept the same cycle, enter DROP.
REQ-026 SHALL, in DROP, drive imem_req=0, discard the next imem_rvalid data, then enter REQ.
REQ-027 SHALL, on redirect coinciding with imem_rvalid in WAIT, discard that data and enter REQ.
REQ-028 SHALL, on redirect in REQ without accept, stay in REQ with imem_addr switching to the new target next cycle.
REQ-029 SHALL ignore imem_rvalid in IDLE and REQ.
REQ-030 SHALL produce first-fetch latency: reset release -> imem_req at cycle 2 (IDLE, REQ); rvalid at cycle N -> out_valid=1 at cycle N+1.

Reset
REQ-031 SHALL, on reset, asynchronously set state=IDLE, pc=RESET_PC, buffer invalid, out_instruction=NOP_INSTR, out_pc=0, out_valid=0, imem_req=0.
REQ-032 SHALL, on reset mid-transaction, abandon the outstanding request; responses arriving after reset release SHALL be ignored per REQ-029.

Verification
REQ-033 Zero-wait memory (ready=1, rvalid one cycle after accept), no stall -> out_pc sequence 0,4,8,... with out_valid=1, imem_rdata passed unchanged.
REQ-034 Buffer full at pc 0x8, if_id_stall=1 for 3 cycles -> out_pc=0x8 held, imem_req=0 after the next accept, no instruction lost or duplicated on release.
REQ-035 branch_taken with branch_target=0x103 while WAIT on pc 0x10 -> DROP, rvalid data for 0x10 discarded, next imem_addr=0x100, out_valid=0 until 0x100 returns.
REQ-036 branch_taken and if_id_stall both 1 with buffer valid -> out_valid=0, out_instruction=0x00000013 next cycle, fetch resumes at target.
REQ-037 imem_ready low for 4 cycles at pc 0x20 -> imem_addr=0x20 stable, pc advances to 0x24 only on accept.
REQ-038 reset asserted in WAIT, released, stale rvalid arrives in IDLE -> ignored; first out_pc=RESET_PC.
